// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
// spi_pkg
// Shared types for the parameterised SPI slave:
//   state_t    - frame FSM states (IDLE, LOAD, SHIFT)
//   spi_mode_t - SPI clock mode captured at the start of each frame
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
// spi_sync_edge
// Multi-flop synchroniser for one asynchronous input, followed by
// rising/falling edge detection on the synchronised value.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset (all flops go to RESET_VAL)
//   din  - asynchronous input
//   sync - synchronised input (SYNC_STAGES flops after din)
//   rise - one-cycle pulse when sync goes 0->1
//   fall - one-cycle pulse when sync goes 1->0
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stage_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg[0] <= RESET_VAL;
        end else begin
            stage_reg[0] <= din;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stage_reg[gi] <= RESET_VAL;
                end else begin
                    stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    // Previous synchronised value, used only for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_reg <= RESET_VAL;
        end else begin
            prev_reg <= stage_reg[SYNC_STAGES-1];
        end
    end

    assign sync = stage_reg[SYNC_STAGES-1];
    assign rise = sync & ~prev_reg;
    assign fall = ~sync & prev_reg;

endmodule

// File: rtl/spi_slave_param.sv
`timescale 1ns/1ps
// spi_slave_param
// SPI slave, all four CPOL/CPHA modes, parameterised word width and bit
// order. SPI inputs are oversampled by clk (at least 4x sclk).
// Ports:
//   clk, rst            - system clock, asynchronous active-low reset
//   cfg_cpol, cfg_cpha  - SPI mode, captured at the start of each frame
//   sclk, ss_n, mosi    - SPI bus inputs (asynchronous)
//   miso, miso_oe       - SPI bus output and its enable
//   tx_data/valid/ready - one-word transmit holding register, valid/ready
//   rx_data, rx_valid   - last received word, one-cycle update pulse
//   busy                - frame in progress
//   tx_underrun         - pulse when a word starts with no tx word held
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic sclk_sync, sclk_rise, sclk_fall;
    logic ss_sync, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_stage_reg;
    logic mosi_sync;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .sync (sclk_sync),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss_n),
        .sync (ss_sync),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    // mosi goes through the same depth as sclk so that data and clock
    // edges stay aligned after synchronisation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_stage_reg[0] <= 1'b0;
        end else begin
            mosi_stage_reg[0] <= mosi;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_mosi_stage
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mosi_stage_reg[gi] <= 1'b0;
                end else begin
                    mosi_stage_reg[gi] <= mosi_stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign mosi_sync = mosi_stage_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    spi_mode_t             mode_reg;
    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [DATA_WIDTH-1:0] tx_shift_reg;
    logic [DATA_WIDTH-2:0] rx_part_reg;   // bits received before the last one
    logic [DATA_WIDTH-1:0] hold_data_reg;
    logic                  hold_full_reg;
    logic [DATA_WIDTH-1:0] rx_data_reg;
    logic                  rx_valid_reg;
    logic                  underrun_reg;

    // ------------------------------------------------------------------
    // Edge classification. After a leading edge sclk sits at the level
    // opposite to CPOL; after a trailing edge it is back at CPOL.
    // ------------------------------------------------------------------
    logic sclk_edge, leading_edge, trailing_edge, sample_edge, shift_edge;
    logic do_sample, word_done, do_shift, load_now, tx_accept;

    assign sclk_edge     = sclk_rise | sclk_fall;
    assign leading_edge  = sclk_edge & (sclk_sync ^ mode_reg.cpol);
    assign trailing_edge = sclk_edge & ~(sclk_sync ^ mode_reg.cpol);
    assign sample_edge   = mode_reg.cpha ? trailing_edge : leading_edge;
    assign shift_edge    = mode_reg.cpha ? leading_edge  : trailing_edge;

    assign do_sample = (state_reg == SHIFT) & sample_edge;
    assign word_done = do_sample & (bit_cnt_reg == LAST_BIT);
    // A shift edge seen while the bit counter is 0 belongs to the start of
    // a word: with CPHA=1 it is the first leading edge, with CPHA=0 it is
    // the trailing edge of the previous word's last bit. Either way the
    // freshly loaded first bit must stay on miso.
    assign do_shift  = (state_reg == SHIFT) & shift_edge & (bit_cnt_reg != '0);
    assign load_now  = (state_reg == LOAD) & ~ss_sync;
    assign tx_accept = tx_valid & ~hold_full_reg;

    // ------------------------------------------------------------------
    // Bit-order dependent data paths
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rx_word, tx_advanced;
    logic [DATA_WIDTH-2:0] rx_part_next;
    logic                  tx_bit;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign rx_word      = {rx_part_reg, mosi_sync};
            assign rx_part_next = {rx_part_reg[DATA_WIDTH-3:0], mosi_sync};
            assign tx_advanced  = {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
            assign tx_bit       = tx_shift_reg[DATA_WIDTH-1];
        end else begin : g_lsb_first
            assign rx_word      = {mosi_sync, rx_part_reg};
            assign rx_part_next = {mosi_sync, rx_part_reg[DATA_WIDTH-2:1]};
            assign tx_advanced  = {1'b0, tx_shift_reg[DATA_WIDTH-1:1]};
            assign tx_bit       = tx_shift_reg[0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ss_fall) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (word_done) state_next = LOAD;
            default: state_next = IDLE;
        endcase
        if (ss_sync) begin
            state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_reg      <= '0;
            bit_cnt_reg   <= '0;
            tx_shift_reg  <= '0;
            rx_part_reg   <= '0;
            hold_data_reg <= '0;
            hold_full_reg <= 1'b0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            underrun_reg <= 1'b0;

            if (ss_fall) begin
                mode_reg.cpol <= cfg_cpol;
                mode_reg.cpha <= cfg_cpha;
            end

            // Holding register: LOAD drains it (using the old content even
            // if a new word is accepted in the same cycle); when it is empty
            // a new word can be accepted, also during an underrunning LOAD.
            if (load_now && hold_full_reg) begin
                hold_full_reg <= 1'b0;
            end else if (tx_accept) begin
                hold_data_reg <= tx_data;
                hold_full_reg <= 1'b1;
            end

            if (ss_rise) begin
                tx_shift_reg <= '0;
            end else if (load_now) begin
                if (hold_full_reg) begin
                    tx_shift_reg <= hold_data_reg;
                end else begin
                    tx_shift_reg <= '0;
                    underrun_reg <= 1'b1;
                end
            end else if (do_shift) begin
                tx_shift_reg <= tx_advanced;
            end

            // Deselect discards any partial word.
            if (ss_sync) begin
                bit_cnt_reg <= '0;
                rx_part_reg <= '0;
            end else if (do_sample) begin
                if (bit_cnt_reg == LAST_BIT) begin
                    bit_cnt_reg  <= '0;
                    rx_data_reg  <= rx_word;
                    rx_valid_reg <= 1'b1;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    rx_part_reg <= rx_part_next;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign miso_oe     = ~ss_sync;
    assign miso        = miso_oe & tx_bit;
    assign tx_ready    = ~hold_full_reg;
    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign busy        = (state_reg != IDLE);
    assign tx_underrun = underrun_reg;

endmodule
